// File: rtl/probe_conditioner.sv
// Probe input conditioning: async-to-clk synchroniser, per-bit persistence
// filter and sticky activity flags feeding the correlator probe input.

module probe_filter_bit #(
  parameter int FILTER_LEN = 4,
  parameter int FILTER_W   = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_cg,
  input  logic i_bypass,
  input  logic i_activityClear,
  input  logic i_s,
  output logic o_probe,
  output logic o_activity,
  output logic o_actNext
);
  localparam logic [FILTER_W-1:0] CNT_LAST = FILTER_W'(FILTER_LEN - 1);

  logic [FILTER_W-1:0] r_cnt, w_cntNext;
  logic                r_probe, w_probeNext;
  logic                r_act, w_set;

  always_comb begin
    w_cntNext   = r_cnt;
    w_probeNext = r_probe;
    if (i_cg) begin
      if (i_bypass) begin
        w_probeNext = i_s;
        w_cntNext   = '0;
      end else if (i_s == r_probe) begin
        w_cntNext = '0;
      end else if (r_cnt == CNT_LAST) begin
        w_probeNext = i_s;
        w_cntNext   = '0;
      end else begin
        w_cntNext = r_cnt + FILTER_W'(1);
      end
    end
  end

  // Clear is honoured even while gated; a set in the same cycle wins.
  assign w_set     = (w_probeNext != r_probe);
  assign o_actNext = w_set | (r_act & ~i_activityClear);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt   <= '0;
      r_probe <= 1'b0;
      r_act   <= 1'b0;
    end else begin
      r_cnt   <= w_cntNext;
      r_probe <= w_probeNext;
      r_act   <= o_actNext;
    end
  end

  assign o_probe    = r_probe;
  assign o_activity = r_act;
endmodule

module probe_conditioner #(
  parameter int N_PROBE    = 64,
  parameter int N_SYNC     = 2,
  parameter int FILTER_LEN = 4,
  parameter int FILTER_W   = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_cg,
  input  logic               i_bypass,
  input  logic               i_activityClear,
  input  logic [N_PROBE-1:0] i_probe,
  output logic [N_PROBE-1:0] o_probe,
  output logic [N_PROBE-1:0] o_activity,
  output logic               o_anyActivity
);
  logic [N_SYNC-1:0][N_PROBE-1:0] r_sync;
  logic [N_PROBE-1:0]             w_s, w_actNext;
  logic                           r_any;

  // Synchroniser runs ungated so it never holds stale metastable samples.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync <= '0;
    end else begin
      r_sync[0] <= i_probe;
      for (int k = 1; k < N_SYNC; k++) r_sync[k] <= r_sync[k-1];
    end
  end

  assign w_s = r_sync[N_SYNC-1];

  for (genvar g = 0; g < N_PROBE; g++) begin : g_lane
    probe_filter_bit #(
      .FILTER_LEN(FILTER_LEN),
      .FILTER_W  (FILTER_W)
    ) u_bit (
      .i_clk          (i_clk),
      .i_rst          (i_rst),
      .i_cg           (i_cg),
      .i_bypass       (i_bypass),
      .i_activityClear(i_activityClear),
      .i_s            (w_s[g]),
      .o_probe        (o_probe[g]),
      .o_activity     (o_activity[g]),
      .o_actNext      (w_actNext[g])
    );
  end

  // Reduced from the next flag value so it lines up with o_activity.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_any <= 1'b0;
    else       r_any <= |w_actNext;
  end

  assign o_anyActivity = r_any;
endmodule

// File: tb/tb_probe_conditioner.sv
// Directed bench for probe_conditioner at default parameters
// (N_SYNC=2, FILTER_LEN=4): per-cycle vector table plus reset sequences.

module tb_probe_conditioner;
  localparam logic [63:0] ALL = {64{1'b1}};
  localparam logic [63:0] B5  = 64'h20;
  localparam logic [63:0] B7  = 64'h80;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_cg = 1'b1;
  logic        i_bypass = 1'b0;
  logic        i_activityClear = 1'b0;
  logic [63:0] i_probe = '0;
  logic [63:0] o_probe, o_activity;
  logic        o_anyActivity;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [63:0] probe;
    logic        cg, byp, clr;
    logic [63:0] ep, ea;
    logic        eany;
  } vec_t;

  vec_t tbl[$];

  probe_conditioner dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_cg           (i_cg),
    .i_bypass       (i_bypass),
    .i_activityClear(i_activityClear),
    .i_probe        (i_probe),
    .o_probe        (o_probe),
    .o_activity     (o_activity),
    .o_anyActivity  (o_anyActivity)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [63:0] ep, input logic [63:0] ea,
                         input logic eany);
    chk({tag, " o_probe"}, o_probe, ep);
    chk({tag, " o_activity"}, o_activity, ea);
    chk({tag, " o_anyActivity"}, {63'b0, o_anyActivity}, {63'b0, eany});
  endtask

  task automatic add(input logic [63:0] probe, input logic cg, input logic byp,
                     input logic clr, input logic [63:0] ep, input logic [63:0] ea,
                     input logic eany);
    vec_t v;
    v.probe = probe; v.cg = cg; v.byp = byp; v.clr = clr;
    v.ep = ep; v.ea = ea; v.eany = eany;
    tbl.push_back(v);
  endtask

  initial begin
    // All-ones back to zero, then clear the flags.
    for (int k = 1; k <= 6; k++) add('0, 1, 0, 0, (k < 6) ? ALL : '0, ALL, 1);
    add('0, 1, 0, 1, '0, '0, 0);
    // 3-cycle glitch on bit 5 is rejected.
    for (int k = 1; k <= 8; k++) add((k <= 3) ? B5 : '0, 1, 0, 0, '0, '0, 0);
    // 4-cycle pulse passes: high on rows 6..9.
    for (int k = 1; k <= 12; k++)
      add((k <= 4) ? B5 : '0, 1, 0, 0, (k >= 6 && k <= 9) ? B5 : '0,
          (k >= 6) ? B5 : '0, k >= 6);
    add('0, 1, 0, 1, '0, '0, 0);
    // Bypass: 1-cycle pulse on bit 0 reappears 3 cycles later.
    for (int k = 1; k <= 6; k++)
      add((k == 1) ? 64'h1 : '0, 1, 1, 0, (k == 3) ? 64'h1 : '0,
          (k >= 3) ? 64'h1 : '0, k >= 3);
    add('0, 1, 0, 1, '0, '0, 0);
    // Flags on bits 1,2; clear coincides with bit 2 toggling, then plain clear.
    for (int k = 1; k <= 12; k++) begin
      logic [63:0] p, ep, ea;
      p  = (k <= 4) ? 64'h6 : (k <= 9) ? 64'h2 : 64'h0;
      ep = (k <= 2) ? 64'h0 : (k <= 6) ? 64'h6 : (k <= 11) ? 64'h2 : 64'h0;
      ea = (k <= 2) ? 64'h0 : (k <= 6) ? 64'h6 : (k <= 8) ? 64'h4 :
           (k <= 11) ? 64'h0 : 64'h2;
      add(p, 1, 1, (k == 7 || k == 9), ep, ea, ea != 0);
    end
    add('0, 1, 0, 1, '0, '0, 0);
    // Gate drops for 10 cycles at cnt=2 on bit 7; gated clear at the end.
    for (int k = 1; k <= 23; k++)
      add((k <= 16) ? B7 : '0, !(k >= 5 && k <= 14) && k != 23, 0, k == 23,
          (k >= 16 && k <= 21) ? B7 : '0, (k >= 16 && k <= 22) ? B7 : '0,
          k >= 16 && k <= 22);

    // Reset with all probes high.
    i_probe = ALL;
    tick();
    tick();
    chk_all("reset", '0, '0, 0);
    i_rst = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk_all($sformatf("rel%0d", k), (k == 6) ? ALL : '0, (k == 6) ? ALL : '0, k == 6);
    end

    for (int r = 0; r < tbl.size(); r++) begin
      i_probe = tbl[r].probe;
      i_cg = tbl[r].cg;
      i_bypass = tbl[r].byp;
      i_activityClear = tbl[r].clr;
      tick();
      chk_all($sformatf("vec%0d", r), tbl[r].ep, tbl[r].ea, tbl[r].eany);
    end
    i_cg = 1'b1;
    i_bypass = 1'b0;
    i_activityClear = 1'b0;

    // Async reset while bits are mid-qualification.
    i_probe = 64'hF0;
    for (int k = 1; k <= 6; k++) tick();
    chk_all("pre_rst", 64'hF0, 64'hF0, 1);
    i_probe = 64'hFF00;
    for (int k = 1; k <= 3; k++) tick();
    #2;
    i_rst = 1'b1;
    #1;
    chk_all("async_rst", '0, '0, 0);
    tick();
    i_rst = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk_all($sformatf("requal%0d", k), (k == 6) ? 64'hFF00 : '0,
              (k == 6) ? 64'hFF00 : '0, k == 6);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
